// File: rtl/blake_work_pkg.sv
// Shared constants and receive-state encoding for the serial work-word path.
package blake_work_pkg;
  localparam int WORK_BITS  = 384;
  localparam int DATA1_BITS = 256;
  localparam int DATA2_BITS = 128;
  localparam int CNT_BITS   = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_OVERRUN  = 2'd2
  } rx_state_e;
endpackage

// File: rtl/work_shift_rx_if.sv
// Serial work-bit input and decoded work-word output bundle.
interface work_shift_rx_if;
  import blake_work_pkg::*;

  logic                  loadnonce;
  logic                  shift;
  logic                  din;
  logic [DATA1_BITS-1:0] data1;
  logic [DATA2_BITS-1:0] data2;
  logic                  work_valid;
  logic                  busy;
  logic                  len_err;

  modport master (
    output loadnonce, shift, din,
    input  data1, data2, work_valid, busy, len_err
  );

  modport slave (
    input  loadnonce, shift, din,
    output data1, data2, work_valid, busy, len_err
  );
endinterface

// File: rtl/work_bit_counter.sv
// Received-bit counter; term_o flags the enable that delivers the final bit of a word.
module work_bit_counter
  import blake_work_pkg::*;
(
  input  logic hash_clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // Saturates at WORK_BITS so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_BITS'(WORK_BITS))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = en_i && (cnt_q == CNT_BITS'(WORK_BITS - 1));
endmodule

// File: rtl/work_shift_rx.sv
// Serial 384-bit work receiver (MSB first) producing data1/data2 and status pulses.
// WORK_SHIFT_LEN_CHECK_EN enables the OVERRUN state and len_err reporting.
module work_shift_rx
  import blake_work_pkg::*;
(
  input  logic            hash_clk,
  input  logic            reset,
  work_shift_rx_if.slave  w
);
  rx_state_e             state_q;
  logic [WORK_BITS-1:0]  shreg_q, shreg_d;
  logic [DATA1_BITS-1:0] data1_q;
  logic [DATA2_BITS-1:0] data2_q;
  logic                  work_valid_q;
  logic                  busy_q;
  logic                  sample, cnt_clr, term;
`ifdef WORK_SHIFT_LEN_CHECK_EN
  logic                  len_err_q;
  logic                  ovr_err_q;
`endif

  // loadnonce suppresses any bit presented in the same cycle.
  assign sample  = w.shift && !w.loadnonce &&
                   ((state_q == ST_IDLE) || (state_q == ST_SHIFTING));
  assign cnt_clr = w.loadnonce || term || ((state_q == ST_SHIFTING) && !w.shift);
  assign shreg_d = {shreg_q[WORK_BITS-2:0], w.din};

  work_bit_counter u_cnt (
    .hash_clk (hash_clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (sample),
    .term_o   (term)
  );

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      work_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef WORK_SHIFT_LEN_CHECK_EN
      len_err_q    <= 1'b0;
      ovr_err_q    <= 1'b0;
`endif
    end else begin
      work_valid_q <= 1'b0;
`ifdef WORK_SHIFT_LEN_CHECK_EN
      len_err_q    <= 1'b0;
`endif
      if (sample) shreg_q <= shreg_d;

      if (w.loadnonce) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
`ifdef WORK_SHIFT_LEN_CHECK_EN
        ovr_err_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (w.shift) begin
              state_q <= ST_SHIFTING;
              busy_q  <= 1'b1;
            end
          end
          ST_SHIFTING: begin
            if (!w.shift) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
`ifdef WORK_SHIFT_LEN_CHECK_EN
              len_err_q <= 1'b1;
`endif
            end else if (term) begin
              data1_q      <= shreg_d[WORK_BITS-1:DATA2_BITS];
              data2_q      <= shreg_d[DATA2_BITS-1:0];
              work_valid_q <= 1'b1;
              busy_q       <= 1'b0;
`ifdef WORK_SHIFT_LEN_CHECK_EN
              state_q      <= ST_OVERRUN;
              ovr_err_q    <= 1'b0;
`else
              state_q      <= ST_IDLE;
`endif
            end
          end
`ifdef WORK_SHIFT_LEN_CHECK_EN
          ST_OVERRUN: begin
            if (!w.shift) begin
              state_q <= ST_IDLE;
            end else if (!ovr_err_q) begin
              len_err_q <= 1'b1;
              ovr_err_q <= 1'b1;
            end
          end
`endif
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w.data1      = data1_q;
  assign w.data2      = data2_q;
  assign w.work_valid = work_valid_q;
  assign w.busy       = busy_q;
`ifdef WORK_SHIFT_LEN_CHECK_EN
  assign w.len_err    = len_err_q;
`else
  assign w.len_err    = 1'b0;
`endif
endmodule

// File: doc/work_shift_rx.md
WORK_SHIFT_RX -- requirements
Module: work_shift_rx

Interface
REQ-001 SHALL: hash_clk  input  1  single clock; all logic is on the rising edge.
REQ-002 SHALL: reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL: loadnonce  input  1  new-work strobe (one hash_clk cycle); restarts reception.
REQ-004 SHALL: shift  input  1  bit-valid qualifier for din.
REQ-005 SHALL: din  input  1  serial work bit, MSB first.
REQ-006 SHALL: data1  output  256  last complete midstate.
REQ-007 SHALL: data2  output  128  last complete data2 word.
REQ-008 SHALL: work_valid  output  1  one-cycle pulse when data1/data2 update.
REQ-009 SHALL: busy  output  1  high while a word is partially received.
REQ-010 SHALL: len_err  output  1  one-cycle pulse on a malformed shift burst.

Function
REQ-011 SHALL: the wire format is 384 bits per word: data1[255] first through data1[0], then data2[127] through data2[0]; one bit per cycle with shift=1.
REQ-012 SHALL: the upstream burst has shift high for exactly 384 consecutive cycles, starting 2 cycles after loadnonce.
REQ-013 SHALL: states are IDLE, SHIFTING and OVERRUN; the 9-bit bit counter runs 0..384.
REQ-014 SHALL: in IDLE, shift=1 samples din, sets count=1 and enters SHIFTING.
REQ-015 SHALL: in SHIFTING, shift=1 samples din and increments count.
REQ-016 SHALL: when the 384th bit is sampled, the cycle after sets data1/data2 from the assembled register and pulses work_valid, with count=0 and state OVERRUN.
REQ-017 SHALL: in OVERRUN, shift=1 bits are discarded; the first such bit pulses len_err once per burst; shift=0 returns to IDLE.
REQ-018 SHALL: in SHIFTING, shift=0 with count in 1..383 pulses len_err next cycle, discards the partial word and returns to IDLE; data1/data2 are unchanged.
REQ-019 SHALL: loadnonce in any state clears count and enters IDLE; a shift bit in the same cycle is discarded; loadnonce wins over every simultaneous event.
REQ-020 SHALL: if loadnonce coincides with the 384th bit, that word is discarded and there is no work_valid.
REQ-021 SHALL: busy = (state==SHIFTING), registered.
REQ-022 SHALL: latency from the 384th sampled bit to work_valid is 1 cycle; data1/data2 are valid in the same cycle as work_valid and hold until the next completed word.
REQ-023 SHALL: the counter never wraps; there is no combinational path from inputs to outputs.

Reset
REQ-024 SHALL: reset synchronously forces IDLE, count=0, data1=0, data2=0, work_valid=0, busy=0, len_err=0, and clears the assembly register.
REQ-025 SHALL: reset mid-burst discards the partial word; the remaining shift=1 cycles after reset release are received as a new word from count 0, and the truncated tail then raises len_err (REQ-018).
REQ-026 SHALL: reset takes priority over loadnonce and shift.

Configuration
REQ-027 SHALL: macro WORK_SHIFT_LEN_CHECK_EN controls length checking.
- Defined: len_err and the OVERRUN state behave per REQ-017/018.
- Not defined: len_err is tied 0, and OVERRUN is replaced by IDLE. Excess bits after the 384th then start a new word, and short bursts are still discarded silently.

Structure
REQ-028 SHALL: shared package blake_work_pkg holds WORK_BITS=384, DATA1_BITS=256, DATA2_BITS=128, CNT_BITS=9 and the state enum; the top-level hub's work shifter uses the same constants.
REQ-029 SHALL: a single sub-module, work_bit_counter (clear, enable, 384-terminal flag), is used; the rest is flat.

Verification
REQ-030 SHALL: loadnonce, then 384 shift cycles carrying data1=0x0123…CDEF pattern and data2=0x80000000_00000000_00000000_00000280 -> work_valid pulses exactly once, 1 cycle after the last bit, with outputs bit-exact.
REQ-031 SHALL: a burst of 200 bits, then shift=0 -> len_err pulses once, no work_valid, busy drops, and outputs keep the previous word.
REQ-032 SHALL: a burst of 390 bits -> work_valid at bit 384 and len_err exactly once at bit 385; bits 385-390 are ignored. Without WORK_SHIFT_LEN_CHECK_EN: work_valid once, len_err always 0.
REQ-033 SHALL: loadnonce asserted at bit 100, then a full 384-bit burst -> the first word is discarded, work_valid once, outputs equal the second word.
REQ-034 SHALL: reset at bit 300 with shift held high to bit 384 -> all outputs 0 during reset; after release, the 84-bit tail is received as a new word and raises len_err once with no work_valid; the next full burst decodes correctly.
REQ-035 SHALL: back-to-back words separated by a single shift=0 cycle, with alternating all-ones/all-zeros data -> two work_valid pulses and correct outputs each time.
